mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory stage of the 5-stage RV32I pipeline; consumes the EXE/MEM registers from execute.
//  Drives the data-memory req/ack port for loads and stores, aligns and extends load data,
//  returns the MEM forwarding value, and registers MEM/WB. Stalls upstream until dmem_ack.
// PARAMETERS
//  XLEN         32  datapath width (matches constants.vh `XLEN)
//  ACK_TIMEOUT  16  cycles spent in WAIT with no ack before a bus error retires the instr
// PORTS
//  clk          in   1     pipeline clock
//  rst_n        in   1     synchronous active-low reset
//  valid_mem    in   1     EXE/MEM holds a live instruction
//  pc_mem       in   XLEN  EXE/MEM pc
//  alu_mem      in   XLEN  ALU result; the effective address for loads and stores
//  rs2_mem      in   XLEN  store data
//  instr_mem    in   XLEN  instruction; opcode [6:0], funct3 [14:12]
//  rd_addr_mem  in   5     destination register
//  dmem_req     out  1     memory request
//  dmem_we      out  1     1 = store
//  dmem_addr    out  XLEN  word-aligned address {alu_mem[XLEN-1:2],2'b00}
//  dmem_wdata   out  XLEN  lane-replicated store data
//  dmem_be      out  4     byte enables
//  dmem_ack     in   1     memory done; rdata valid in the same cycle
//  dmem_rdata   in   XLEN  read word
//  stall_mem    out  1     freeze IF..EXE and hold EXE/MEM stable
//  forward_mem  out  XLEN  = alu_mem (load-use hazards are handled by the hazard unit)
//  valid_wb, pc_wb, alu_wb, load_wb, instr_wb, rd_addr_wb  out  MEM/WB registers
//  bus_err_wb   out  1     retired instruction timed out
// BEHAVIOUR
//  - Access = valid_mem & opcode in {LOAD 0000011, STORE 0100011}.
//  - FSM IDLE/WAIT:
//    IDLE: access -> dmem_req=1 combinationally. Ack in the same cycle -> zero-wait retire.
//          Otherwise go to WAIT with cnt=0.
//    WAIT: dmem_req stays high; addr, we, be and wdata are held stable.
//          Each cycle with no ack, cnt++. On ack -> retire and go to IDLE.
//          cnt==ACK_TIMEOUT-1 with no ack -> retire with bus_err_wb=1, load_wb=0, go to IDLE.
//          If ack and timeout coincide, ack wins.
//  - stall_mem = access & ~dmem_ack & ~timeout_hit.
//  - Non-access instrs retire on the next edge with zero added latency; bubbles give valid_wb=0.
//  - Retire: at the edge, MEM/WB regs <= EXE/MEM fields; valid_wb<=1; load_wb <= aligned rdata.
//  - Load align, lane = alu_mem[1:0]:
//    LB/LBU take byte[lane]; LH/LHU take half[alu_mem[1]]; LW takes the word.
//    LB/LH sign-extend; LBU/LHU zero-extend.
//  - Store:
//    SB: wdata={4{rs2[7:0]}},  be=4'b0001<<lane
//    SH: wdata={2{rs2[15:0]}}, be=4'b0011<<{alu_mem[1],1'b0}
//    SW: wdata=rs2,            be=4'hF
//    Loads: be=4'hF, we=0.
//  - dmem_ack while dmem_req=0 is ignored.
//  - Reset (any state, including mid-WAIT): state<=IDLE, cnt<=0, all MEM/WB regs and
//    bus_err_wb <= 0. dmem_req and stall_mem are forced to 0 while rst_n=0.
// CONFIGURATION
//  Macro MISALIGN_TRAP_EN:
//  - Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, raise no dmem_req and
//    no stall. The instr retires next edge with misalign_wb=1 (extra output port), load_wb=0.
//  - Undefined: no misalign_wb port. Low address bits that do not select a lane are ignored
//    (LW at 0x...3 reads word 0x...0; LH at odd address uses half[addr[1]]).
// STRUCTURE
//  - Shared package rv_pkg: opcode constants OP_LOAD/OP_STORE; funct3 enum mem_size_t
//    (LB,LH,LW,LBU,LHU); mem_state_t {IDLE,WAIT}.
//  - Sub-module load_align (combinational): rdata, addr[1:0], funct3 -> XLEN result.
//  - Store lane and be generation stay inline.
// TESTING
//  1 ALU instr, alu_mem=0x55 -> next edge valid_wb=1, alu_wb=0x55, dmem_req=0, stall_mem=0.
//  2 LB @0x103, rdata=0x80FF_FF7F, ack in same cycle -> load_wb=0xFFFF_FF80,
//    no stall, dmem_addr=0x100.
//  3 SH @0x102, rs2=0x1234_ABCD, ack after 3 cycles:
//    -> be=4'b1100, wdata=0xABCD_ABCD, stall_mem high 3 cycles, retire on 4th edge.
//  4 LW, no ack -> bus_err_wb=1 after ACK_TIMEOUT=16 WAIT cycles. Ack on the final cycle
//    -> normal retire, bus_err_wb=0.
//  5 rst_n=0 mid-WAIT -> next cycle state IDLE, dmem_req=0, valid_wb=0, stall_mem=0.
//  6 MISALIGN_TRAP_EN, LW @0x102 -> no req, misalign_wb=1 next edge. Undefined: reads 0x100.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: memory opcodes, load/store size encodings
// (funct3) and the memory-stage handshake states.
package rv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Stores reuse the LB/LH/LW codes for SB/SH/SW.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the byte/half/word from a read word based
// on the low address bits and sign- or zero-extends according to funct3.
module load_align
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = rdata[{addr[1], 4'b0000} +: 16];
    case (funct3)
      LB:      result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LH:      result = {{(XLEN-16){half_sel[15]}}, half_sel};
      LBU:     result = {{(XLEN-8){1'b0}}, byte_sel};
      LHU:     result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: data-memory req/ack handshake with ack timeout, store lane
// steering, load alignment and the MEM/WB register. Optional MISALIGN_TRAP_EN.
module mem_stage
  import rv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_mem,
  input  logic [XLEN-1:0] pc_mem,
  input  logic [XLEN-1:0] alu_mem,
  input  logic [XLEN-1:0] rs2_mem,
  input  logic [XLEN-1:0] instr_mem,
  input  logic [4:0]      rd_addr_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_mem,
  output logic [XLEN-1:0] forward_mem,
  output logic            valid_wb,
  output logic [XLEN-1:0] pc_wb,
  output logic [XLEN-1:0] alu_wb,
  output logic [XLEN-1:0] load_wb,
  output logic [XLEN-1:0] instr_wb,
  output logic [4:0]      rd_addr_wb,
  output logic            bus_err_wb
`ifdef MISALIGN_TRAP_EN
  ,output logic           misalign_wb
`endif
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT);

  mem_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       funct3;
  logic             is_load, is_store, misalign, access;
  logic             timeout_hit, stall;
  logic [XLEN-1:0]  aligned;

  assign funct3   = instr_mem[14:12];
  assign is_load  = instr_mem[6:0] == OP_LOAD;
  assign is_store = instr_mem[6:0] == OP_STORE;

`ifdef MISALIGN_TRAP_EN
  assign misalign = valid_mem & (is_load | is_store) &
                    (((funct3[1:0] == 2'b01) & alu_mem[0]) |
                     ((funct3[1:0] == 2'b10) & (alu_mem[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign access      = valid_mem & (is_load | is_store) & ~misalign;
  assign dmem_req    = rst_n & access;
  assign stall_mem   = rst_n & stall;
  assign forward_mem = alu_mem;
  assign dmem_addr   = {alu_mem[XLEN-1:2], 2'b00};
  assign dmem_we     = is_store;

  always_comb begin
    dmem_wdata = rs2_mem;
    dmem_be    = 4'hF;
    if (is_store) begin
      case (funct3)
        LB: begin
          dmem_wdata = {4{rs2_mem[7:0]}};
          dmem_be    = 4'b0001 << alu_mem[1:0];
        end
        LH: begin
          dmem_wdata = {2{rs2_mem[15:0]}};
          dmem_be    = 4'b0011 << {alu_mem[1], 1'b0};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // An ack arriving on the final WAIT cycle beats the timeout.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (access && !dmem_ack) begin
          state_next = WAIT;
          cnt_next   = '0;
        end
      end
      WAIT: begin
        if (!access || dmem_ack) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    stall = access & ~dmem_ack & ~timeout_hit;
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem_rdata),
    .addr   (alu_mem[1:0]),
    .funct3 (funct3),
    .result (aligned)
  );

  // While stalled, WB sees a bubble so the previous instruction is not retired twice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_wb    <= 1'b0;
      pc_wb       <= '0;
      alu_wb      <= '0;
      load_wb     <= '0;
      instr_wb    <= '0;
      rd_addr_wb  <= '0;
      bus_err_wb  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_wb <= 1'b0;
`endif
    end else if (stall) begin
      valid_wb    <= 1'b0;
      bus_err_wb  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_wb <= 1'b0;
`endif
    end else begin
      valid_wb    <= valid_mem;
      pc_wb       <= pc_mem;
      alu_wb      <= alu_mem;
      load_wb     <= (access && is_load && dmem_ack) ? aligned : '0;
      instr_wb    <= instr_mem;
      rd_addr_wb  <= rd_addr_mem;
      bus_err_wb  <= timeout_hit;
`ifdef MISALIGN_TRAP_EN
      misalign_wb <= misalign;
`endif
    end
  end

endmodule
